// File: rtl/cp0_defs.sv
// cp0_defs: shared definitions for the CP0 exception/interrupt unit.
// Contents:
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - ExcCode values carried down the pipeline
//   - SR and Cause bit positions
//   - default handler entry address and PRId value
//   - helpers that pack the implemented fields into 32-bit register images
package cp0_defs;

    typedef enum logic [4:0] {
        CP0_SR    = 5'd12,
        CP0_CAUSE = 5'd13,
        CP0_EPC   = 5'd14,
        CP0_PRID  = 5'd15
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL_DEF   = 32'h2024_0707;

    function automatic logic [31:0] sr_word(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] w;
        w                      = '0;
        w[SR_IM_LO +: 6]       = im;
        w[SR_EXL]              = exl;
        w[SR_IE]               = ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] w;
        w                      = '0;
        w[CAUSE_BD]            = bd;
        w[CAUSE_IP_LO +: 6]    = ip;
        w[CAUSE_EXC_LO +: 5]   = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: Coprocessor-0 exception/interrupt controller at the M stage.
// Decides whether to take an interrupt or synchronous exception, keeps
// SR/Cause/EPC/PRId, serves mtc0/mfc0 and provides EPC for eret.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   hw_int      in   [5:0] level IRQ lines (0 timer0, 1 timer1, 2 external)
//   m_pc        in   [31:0] PC of the instruction in M
//   m_bd        in   M instruction is in a branch delay slot
//   m_exc_code  in   [4:0] pending exception code from M (0 = none)
//   m_eret      in   eret in M
//   we          in   mtc0 write enable
//   cp0_addr    in   [4:0] CP0 register number
//   wdata       in   [31:0] mtc0 data
//   rdata       out  [31:0] mfc0 data (combinational, pre-edge value)
//   exc_req     out  flush and redirect to handler (combinational)
//   handler_pc  out  [31:0] handler entry address
//   epc_out     out  [31:0] registered EPC for eret redirect
module cp0_exc_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter logic [31:0] PRID_VAL   = PRID_VAL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc_code,
    input  logic        m_eret,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        exc_req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_taken;
    logic [31:0] victim_pc;

    // Raw hw_int is used so an interrupt is seen in the same cycle it rises.
    assign int_req   = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_taken = (m_exc_code != 5'd0) & ~sr_exl_q;
    assign exc_req   = int_req | exc_taken;

    // A delay-slot victim restarts at its branch.
    assign victim_pc = m_bd ? (m_pc - 32'd4) : m_pc;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        cause_ip_d  = hw_int;

        if (exc_req) begin
            // Taking the event wins over any mtc0 in the same cycle.
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : m_exc_code;
            cause_bd_d  = m_bd;
            epc_d       = victim_pc & ~32'd3;
        end else begin
            if (m_eret) begin
                sr_exl_d = 1'b0;
            end
            if (we) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im_d  = wdata[SR_IM_LO +: 6];
                        sr_exl_d = wdata[SR_EXL];
                        sr_ie_d  = wdata[SR_IE];
                    end
                    CP0_EPC: epc_d = wdata & ~32'd3;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (cp0_addr)
            CP0_SR:    rdata = sr_word(sr_im_q, sr_exl_q, sr_ie_q);
            CP0_CAUSE: rdata = cause_word(cause_bd_q, cause_ip_q, cause_exc_q);
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID_VAL;
            default:   rdata = '0;
        endcase
    end

    assign handler_pc = HANDLER_PC;
    assign epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID = 32'h2024_0707;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_int;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    always #5 clk = ~clk;

    cp0_exc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .hw_int     (hw_int),
        .m_pc       (m_pc),
        .m_bd       (m_bd),
        .m_exc_code (m_exc_code),
        .m_eret     (m_eret),
        .we         (we),
        .cp0_addr   (cp0_addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .exc_req    (exc_req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    typedef struct {
        logic [5:0]  hw;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  code;
        logic        eret;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        int          id;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    localparam int NV = 34;
    vec_t vt[NV];
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, id, act, want);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] hw, input logic [31:0] pc, input logic bd,
                                input logic [4:0] code, input logic eret, input logic w,
                                input logic [4:0] addr, input logic [31:0] wd,
                                input logic req, input logic [31:0] rd, input logic [31:0] epc);
        vec_t v;
        v.hw = hw; v.pc = pc; v.bd = bd; v.code = code; v.eret = eret; v.we = w;
        v.addr = addr; v.wdata = wd; v.req = req; v.rd = rd; v.epc = epc;
        return v;
    endfunction

    // Scoreboard monitor: compares combinational outputs just before each rising edge.
    always begin : mon
        exp_t e;
        @(negedge clk);
        #4;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("exc_req", e.id, {31'd0, exc_req}, {31'd0, e.req});
            chk("rdata",   e.id, rdata, e.rd);
            chk("epc_out", e.id, epc_out, e.epc);
        end
    end

    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        hw_int = v.hw; m_pc = v.pc; m_bd = v.bd; m_exc_code = v.code;
        m_eret = v.eret; we = v.we; cp0_addr = v.addr; wdata = v.wdata;
        e.id = id; e.req = v.req; e.rd = v.rd; e.epc = v.epc;
        sbq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             hw    pc        bd  code eret we addr wdata          req rd             epc
        vt[0]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd12, 32'h0,        0, 32'h0,        32'h0);
        vt[1]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd13, 32'h0,        0, 32'h0,        32'h0);
        vt[2]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h0,        32'h0);
        vt[3]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd15, 32'h0,        0, PRID,         32'h0);
        vt[4]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd0,  32'h0,        0, 32'h0,        32'h0);
        // timer interrupt
        vt[5]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd12, 32'h401,      0, 32'h0,        32'h0);
        vt[6]  = mk(6'd1, 32'h3010, 0, 5'd0,  0, 0, 5'd12, 32'h0,        1, 32'h401,      32'h0);
        vt[7]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd13, 32'h0,        0, 32'h400,      32'h3010);
        vt[8]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h3010,     32'h3010);
        vt[9]  = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd12, 32'h0,        0, 32'h403,      32'h3010);
        // masking while EXL, then eret re-triggers
        vt[10] = mk(6'd1, 32'h0,    0, 5'd0,  0, 0, 5'd12, 32'h0,        0, 32'h403,      32'h3010);
        vt[11] = mk(6'd1, 32'h0,    0, 5'd0,  1, 0, 5'd13, 32'h0,        0, 32'h400,      32'h3010);
        vt[12] = mk(6'd1, 32'h3040, 0, 5'd0,  0, 0, 5'd12, 32'h0,        1, 32'h401,      32'h3010);
        vt[13] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h3040,     32'h3040);
        // delay slot RI with SR=0
        vt[14] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd12, 32'h0,        0, 32'h403,      32'h3040);
        vt[15] = mk(6'd0, 32'h3024, 1, 5'd10, 0, 0, 5'd12, 32'h0,        1, 32'h0,        32'h3040);
        vt[16] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd13, 32'h0,        0, 32'h8000_0028, 32'h3020);
        vt[17] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h3020,     32'h3020);
        vt[18] = mk(6'd0, 32'h3050, 0, 5'd8,  0, 0, 5'd12, 32'h0,        0, 32'h2,        32'h3020);
        // interrupt over exception
        vt[19] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd12, 32'h1001,     0, 32'h2,        32'h3020);
        vt[20] = mk(6'd4, 32'h3100, 0, 5'd12, 0, 0, 5'd13, 32'h0,        1, 32'h8000_0028, 32'h3020);
        vt[21] = mk(6'd4, 32'h3104, 0, 5'd12, 0, 0, 5'd13, 32'h0,        0, 32'h1000,     32'h3100);
        // write collision
        vt[22] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd12, 32'h1001,     0, 32'h1003,     32'h3100);
        vt[23] = mk(6'd4, 32'h3200, 0, 5'd0,  0, 1, 5'd14, 32'hDEAD_BEEF, 1, 32'h3100,    32'h3100);
        vt[24] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h3200,     32'h3200);
        vt[25] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd14, 32'h3007,     0, 32'h3200,     32'h3200);
        vt[26] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd14, 32'h0,        0, 32'h3004,     32'h3004);
        // read-only registers ignore writes
        vt[27] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd13, 32'hFFFF_FFFF, 0, 32'h0,       32'h3004);
        vt[28] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd13, 32'h0,        0, 32'h0,        32'h3004);
        vt[29] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd15, 32'h0,        0, PRID,         32'h3004);
        vt[30] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd15, 32'h0,        0, PRID,         32'h3004);
        // delay slot with unaligned PC
        vt[31] = mk(6'd0, 32'h0,    0, 5'd0,  0, 1, 5'd12, 32'h0,        0, 32'h1003,     32'h3004);
        vt[32] = mk(6'd0, 32'h3027, 1, 5'd4,  0, 0, 5'd0,  32'h0,        1, 32'h0,        32'h3004);
        vt[33] = mk(6'd0, 32'h0,    0, 5'd0,  0, 0, 5'd13, 32'h0,        0, 32'h8000_0010, 32'h3020);

        reset = 1'b0;
        hw_int = '0; m_pc = '0; m_bd = 1'b0; m_exc_code = '0; m_eret = 1'b0;
        we = 1'b0; cp0_addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #4;
        chk("handler_pc", -1, handler_pc, HPC);

        for (int i = 0; i < NV; i++) apply(i, vt[i]);

        // Reset in the middle of an exc_req + mtc0 cycle.
        @(negedge clk);
        hw_int = '0; m_pc = '0; m_bd = 1'b0; m_exc_code = '0; m_eret = 1'b0;
        we = 1'b1; cp0_addr = 5'd12; wdata = 32'h401;
        @(negedge clk);
        reset = 1'b0; hw_int = 6'd1; m_pc = 32'h3300;
        we = 1'b1; cp0_addr = 5'd14; wdata = 32'hDEAD_BEEF;
        #4;
        chk("pre_reset_req", 100, {31'd0, exc_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1; hw_int = '0; we = 1'b0; cp0_addr = 5'd12;
        #4;
        chk("rst_sr",  101, rdata, 32'h0);
        chk("rst_epc", 101, epc_out, 32'h0);
        chk("rst_req", 101, {31'd0, exc_req}, 32'd0);
        @(negedge clk);
        cp0_addr = 5'd13;
        #4;
        chk("rst_cause", 102, rdata, 32'h0);

        @(negedge clk);
        #5;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt controller of the 5-stage MIPS pipeline, placed at the M stage.
- It consumes the level IRQ lines raised by the timer and other bus peripherals, plus exception codes carried down the pipeline.
- It decides whether to take an exception or interrupt, records SR/Cause/EPC, serves mtc0/mfc0, and returns EPC on eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, handler entry address driven on exc_req.
- PRID_VAL, 32'h2024_0707, read-only value of PRId (reg 15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- hw_int  in  6  level IRQ lines; bit 0 = timer0, bit 1 = timer1, bit 2 = external interrupt, bits 5:3 reserved.
- m_pc  in  32  PC of the instruction currently in M (victim PC).
- m_bd  in  1  M instruction sits in a branch delay slot.
- m_exc_code  in  5  pending exception code from M (0 = none; 4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov).
- m_eret  in  1  eret in M.
- we  in  1  mtc0 write enable.
- cp0_addr  in  5  CP0 register number for mtc0/mfc0.
- wdata  in  32  mtc0 data.
- rdata  out  32  mfc0 data (combinational).
- exc_req  out  1  flush pipeline and redirect fetch (combinational).
- handler_pc  out  32  constant HANDLER_PC.
- epc_out  out  32  current EPC, used by eret redirect.

Behaviour:
- Registers:
  - SR(12): only IM[15:10], EXL[1] and IE[0] are implemented; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits 0. Cause is read-only to software.
  - EPC(14): 32 bits, bits [1:0] always 0.
  - PRId(15): PRID_VAL.
  - Any other address reads 0 and ignores writes.
- Reset: SR=0, Cause=0, EPC=0, so exc_req=0 and rdata=0 for address 0.
- IP update: Cause.IP <= hw_int on every clock edge that is not under reset, independent of we/exc_req.
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL. The raw hw_int is used, so there is no one-cycle lag.
- exc_taken = (m_exc_code != 0) & ~SR.EXL.
- exc_req = int_req | exc_taken.
- Priority: interrupt over synchronous exception. When both are present, ExcCode = 0.
- On a clock edge with exc_req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= (int_req ? 0 : m_exc_code).
  - Cause.BD <= m_bd.
  - EPC <= m_bd ? m_pc-4 : m_pc, with bits [1:0] forced to 0.
  - A simultaneous mtc0 is discarded.
- eret (m_eret=1, exc_req=0): SR.EXL <= 0 at the edge. A pending interrupt asserts exc_req in the next cycle.
- mtc0 with exc_req=0:
  - SR: IM, EXL and IE are written from wdata.
  - EPC: written with wdata & ~3.
  - Cause/PRId: ignored.
- mfc0: rdata = register addressed by cp0_addr, pre-edge value. There is no write-through in the same cycle.
- epc_out: the registered EPC. An mtc0 EPC immediately followed by eret must use the new value; the pipeline stalls, so no bypass is needed here.
- Nested events while EXL=1 are masked entirely. hw_int staying high after eret re-triggers.
- Reset mid-operation overrides any exc_req/we in that cycle.

Decomposition:
- Shared package (cp0_defs): register numbers 12/13/14/15, ExcCode constants, SR/Cause bit positions, HANDLER_PC.
- No sub-module. The decision logic and the register file fit in one block of about 150 lines.

Test Plan:
- Reset: drive reset=0 for 2 cycles, then read addr 12/13/14/15 → 0, 0, 0, PRID_VAL; exc_req=0.
- Timer interrupt: mtc0 SR=32'h0000_0401 (IM[10], IE), then hw_int=6'b000001, m_pc=32'h3010, m_bd=0 → exc_req=1 in the same cycle; next cycle Cause=32'h0000_0400, EPC=32'h3010, SR.EXL=1, exc_req=0.
- Delay slot: m_exc_code=10, m_bd=1, m_pc=32'h3024, SR=0 → exc_req=1; Cause=32'h8000_0028, EPC=32'h3020.
- Priority: hw_int[2]=1 with IM[12]=1, IE=1, and m_exc_code=12 in the same cycle → ExcCode=0, one exc_req pulse.
- Masking and eret: while EXL=1, raise hw_int[0] → exc_req=0. Then eret → EXL=0 next cycle and exc_req=1 in the following cycle.
- Write collision: exc_req=1 cycle with we=1, cp0_addr=14, wdata=32'hDEAD_BEEF → EPC holds the victim PC. Later mtc0 EPC=32'h0000_3007 → rdata=32'h0000_3004.
